uart_mem_loader: RTL and testbench

//  Upstream loader active in UART load mode (mode_switch=1): receives a framed byte stream on RX and

---
 rtl/uart_mem_loader_pkg.sv | 14 +
 rtl/uart_mem_loader_rx.sv | 75 +++++++
 rtl/uart_mem_loader.sv | 140 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// loader_pkg: shared state encodings, error codes and frame constants for the UART memory loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, SEL, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_FRAMING = 3'd1;
  localparam logic [2:0] ERR_SEL = 3'd2;
  localparam logic [2:0] ERR_LEN = 3'd3;
  localparam logic [2:0] ERR_CHK = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [7:0] HDR_BYTE = 8'h55;
  localparam logic [7:0] SEL_INSTR = 8'h00;
  localparam logic [7:0] SEL_DATA = 8'h01;
endpackage

// File: rtl/uart_mem_loader_rx.sv
// uart_rx: 8N1 receiver, 16x oversampled (clk, rst, rx in; data, valid, frame_err pulses out)
module uart_rx
  import loader_pkg::*;
#(
  parameter int DIV = 65
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  rx_state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [3:0] os, os_n;
  logic [2:0] bit_i, bit_n;
  logic [7:0] sh, sh_n;
  logic s1, s2, sp, valid_n, ferr_n, tick;
  assign tick = dcnt == DW'(DIV - 1);
  assign data = sh;
  always_comb begin
    state_n = state;
    dcnt_n = tick ? '0 : dcnt + DW'(1);
    os_n = tick ? os + 4'd1 : os;
    bit_n = bit_i;
    sh_n = sh;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      RX_IDLE: if (sp && !s2) begin
        state_n = RX_START;
        dcnt_n = '0;
        os_n = '0;
      end
      RX_START: if (tick && os == 4'd7) begin
        state_n = s2 ? RX_IDLE : RX_DATA;
        os_n = '0;
        bit_n = '0;
      end
      RX_DATA: if (tick && os == 4'd15) begin
        sh_n = {s2, sh[7:1]};
        bit_n = bit_i + 3'd1;
        state_n = bit_i == 3'd7 ? RX_STOP : RX_DATA;
      end
      default: if (tick && os == 4'd15) begin
        state_n = RX_IDLE;
        valid_n = s2;
        ferr_n = !s2;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      dcnt <= '0;
      os <= '0;
      bit_i <= '0;
      sh <= '0;
      {s1, s2, sp} <= 3'b111;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
      os <= os_n;
      bit_i <= bit_n;
      sh <= sh_n;
      {s1, s2, sp} <= {rx, s1, s2};
      valid <= valid_n;
      frame_err <= ferr_n;
    end
  end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART frame parser writing 32-bit words to instr/data memory (wr_* strobe out; busy/done/err status)
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD = 9600,
  parameter int ADDR_W = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);
  localparam int DIV = CLK_FREQ_HZ / (16 * BAUD);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;
  state_t state, state_n;
  logic [7:0] rx_byte, chk, chk_n;
  logic rx_valid, rx_ferr, sel, sel_n, done_n, wr_en_n;
  logic [ADDR_W:0] idx, idx_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [15:0] len, len_n;
  logic [16:0] len_full;
  logic [31:0] word, word_n, word_sh, wr_data_n, gap, gap_n;
  logic [1:0] bcnt, bcnt_n;
  logic [2:0] err_n;
  uart_rx #(.DIV(DIV)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .data(rx_byte), .valid(rx_valid), .frame_err(rx_ferr)
  );
  assign busy = !(state == IDLE || state == DONE || state == ERR);
  assign wr_sel = sel;
  always_comb begin
    state_n = state;
    idx_n = idx;
    len_n = len;
    word_n = word;
    bcnt_n = bcnt;
    chk_n = chk;
    sel_n = sel;
    done_n = done;
    err_n = err;
    wr_en_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    len_full = {1'b0, rx_byte, len[7:0]};
    word_sh = {rx_byte, word[31:8]};
    gap_n = (rx_valid || !busy) ? '0 : gap + 32'd1;
    if (!en) state_n = IDLE;
    else if (rx_ferr) begin
      state_n = ERR;
      err_n = ERR_FRAMING;
    end else if (rx_valid) begin
      case (state)
        SEL: begin
          sel_n = rx_byte[0];
          chk_n = chk ^ rx_byte;
          state_n = rx_byte > SEL_DATA ? ERR : LEN0;
          err_n = rx_byte > SEL_DATA ? ERR_SEL : err;
        end
        LEN0: begin
          len_n[7:0] = rx_byte;
          chk_n = chk ^ rx_byte;
          state_n = LEN1;
        end
        LEN1: begin
          len_n = len_full[15:0];
          chk_n = chk ^ rx_byte;
          state_n = len_full == '0 ? CHK : len_full > MAX_LEN ? ERR : DATA;
          err_n = len_full > MAX_LEN ? ERR_LEN : err;
        end
        DATA: begin
          chk_n = chk ^ rx_byte;
          word_n = word_sh;
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            wr_en_n = 1'b1;
            wr_addr_n = idx[ADDR_W-1:0];
            wr_data_n = word_sh;
            idx_n = idx + (ADDR_W+1)'(1);
            state_n = 17'(idx) + 17'd1 == {1'b0, len} ? CHK : DATA;
          end
        end
        CHK: begin
          state_n = rx_byte == chk ? DONE : ERR;
          done_n = rx_byte == chk;
          err_n = rx_byte == chk ? ERR_NONE : ERR_CHK;
        end
        default: if (rx_byte == HDR_BYTE) begin
          state_n = SEL;
          done_n = 1'b0;
          err_n = ERR_NONE;
          idx_n = '0;
          chk_n = '0;
          bcnt_n = '0;
        end
      endcase
    end else if (busy && gap_n >= 32'(TIMEOUT_CYC)) begin
      state_n = ERR;
      err_n = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      word <= '0;
      bcnt <= '0;
      chk <= '0;
      sel <= 1'b0;
      gap <= '0;
      done <= 1'b0;
      err <= ERR_NONE;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      len <= len_n;
      word <= word_n;
      bcnt <= bcnt_n;
      chk <= chk_n;
      sel <= sel_n;
      gap <= gap_n;
      done <= done_n;
      err <= err_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed frame vectors and corner-case sequences for uart_mem_loader
module tb_uart_mem_loader;
  localparam int BIT = 32;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1;
  logic wr_en, wr_sel, busy, done;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0] err;
  int tests = 0, fails = 0, wr_total = 0;
  logic prev_wr = 1'b0, b2b = 1'b0;
  logic w_sel [64];
  logic [13:0] w_addr [64];
  logic [31:0] w_data [64];
  always #5 clk = ~clk;
  uart_mem_loader #(.CLK_FREQ_HZ(10_000_000), .BAUD(312_500), .ADDR_W(14), .TIMEOUT_CYC(5000)) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );
  always @(negedge clk) begin
    prev_wr <= wr_en;
    if (wr_en && prev_wr) b2b <= 1'b1;
    if (wr_en) begin
      w_sel[wr_total[5:0]] <= wr_sel;
      w_addr[wr_total[5:0]] <= wr_addr;
      w_data[wr_total[5:0]] <= wr_data;
      wr_total <= wr_total + 1;
    end
  end
  typedef struct {
    string name;
    int n;
    logic [127:0] bytes;
    int nwr;
    logic sel;
    logic [31:0] d0;
    logic [31:0] d1;
    logic done;
    logic [2:0] err;
  } vec_t;
  vec_t v [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic send_frame(input logic [127:0] bytes, input int n);
    for (int j = 0; j < n; j++) send_byte(bytes[(n-1-j)*8 +: 8], 1'b1);
  endtask
  initial begin
    int base;
    v[0] = '{"two_words", 13, 128'({8'h55, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28}), 2, 1'b0, 32'h12345678, 32'hDEADBEEF, 1'b1, 3'd0};
    v[1] = '{"len0_ok", 5, 128'({8'h55, 8'h01, 8'h00, 8'h00, 8'h01}), 0, 1'b0, 32'h0, 32'h0, 1'b1, 3'd0};
    v[2] = '{"len0_badchk", 5, 128'({8'h55, 8'h01, 8'h00, 8'h00, 8'h00}), 0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd4};
    v[3] = '{"garbage_then_data", 11, 128'({8'hA0, 8'h13, 8'h55, 8'h01, 8'h01, 8'h00, 8'h0D, 8'hF0,
             8'hFE, 8'hCA, 8'hC9}), 1, 1'b1, 32'hCAFEF00D, 32'h0, 1'b1, 3'd0};
    v[4] = '{"bad_sel", 2, 128'({8'h55, 8'h07}), 0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd2};
    v[5] = '{"recover", 9, 128'({8'h55, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}),
             1, 1'b0, 32'h04030201, 32'h0, 1'b1, 3'd0};
    v[6] = '{"data_badchk", 9, 128'({8'h55, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}),
             1, 1'b0, 32'h44332211, 32'h0, 1'b0, 3'd4};
    v[7] = '{"len_too_big", 4, 128'({8'h55, 8'h00, 8'h01, 8'h40}), 0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd3};
    repeat (3) @(negedge clk);
    chk("rst_outputs", {25'(wr_en), wr_sel, busy, done, err, 1'b0}, 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    rst = 1'b0;
    en = 1'b1;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      base = wr_total;
      send_frame(v[i].bytes, v[i].n);
      repeat (4) @(negedge clk);
      chk({v[i].name, "_wr_count"}, 32'(wr_total - base), 32'(v[i].nwr));
      chk({v[i].name, "_done"}, 32'(done), 32'(v[i].done));
      chk({v[i].name, "_err"}, 32'(err), 32'(v[i].err));
      chk({v[i].name, "_busy"}, 32'(busy), 32'h0);
      for (int k = 0; k < v[i].nwr; k++) begin
        chk({v[i].name, "_sel"}, 32'(w_sel[(base+k) % 64]), 32'(v[i].sel));
        chk({v[i].name, "_addr"}, 32'(w_addr[(base+k) % 64]), 32'(k));
        chk({v[i].name, "_data"}, w_data[(base+k) % 64], k == 0 ? v[i].d0 : v[i].d1);
      end
    end
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b0);
    repeat (4) @(negedge clk);
    chk("framing_err", 32'(err), 32'd1);
    chk("framing_busy", 32'(busy), 32'h0);
    base = wr_total;
    send_frame(128'({8'h55, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB}), 6);
    repeat (4) @(negedge clk);
    chk("stall_busy_early", {31'(err), busy}, 32'h1);
    repeat (4700) @(negedge clk);
    chk("stall_busy_before_timeout", 32'(busy), 32'h1);
    repeat (400) @(negedge clk);
    chk("timeout_err", 32'(err), 32'd5);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_no_write", 32'(wr_total - base), 32'h0);
    base = wr_total;
    send_frame(128'({8'h55, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}), 10);
    chk("en_drop_first_write", 32'(wr_total - base), 32'h1);
    chk("en_drop_first_data", w_data[base % 64], 32'h04030201);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_busy", 32'(busy), 32'h0);
    send_frame(128'({8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h00}), 7);
    repeat (4) @(negedge clk);
    chk("en_drop_no_more_writes", 32'(wr_total - base), 32'h1);
    chk("en_drop_flags_held", {30'(err), done, busy}, 32'h0);
    en = 1'b1;
    send_frame(128'({8'h55, 8'h00, 8'h00, 8'h40}), 4);
    repeat (4) @(negedge clk);
    chk("max_len_accepted", {30'(err), done, busy}, 32'h1);
    send_byte(8'h11, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_flags", {28'(err), wr_en, wr_sel, done, busy}, 32'h0);
    chk("rst_mid_wr_data", wr_data, 32'h0);
    chk("no_back_to_back_wr", 32'(b2b), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
